// File: rtl/demux_scan_seq.sv
// demux_scan_seq
//   Sequencer that drives the data bit and channel select of a 1-to-4 demux.
//   On start it latches din/mode/dwell.
//   It then walks s through channels 0..3, holding each channel for dwell+1 clocks.
//   Mode 0 runs a single sweep; mode 1 repeats sweeps until stop is seen.
//   d is forced to 0 whenever no sweep is active.
// Ports
//   clk, rst_n   : clock, async active-low reset
//   start        : sweep request (only honoured in IDLE)
//   mode         : 0 one-shot, 1 continuous (latched with start)
//   stop         : continuous only; finish at end of current channel dwell
//   din          : data bit to route (latched with start)
//   dwell        : cycles per channel minus 1 (latched with start)
//   d, s         : data bit and channel select to the demux
//   busy         : high during DWELL
//   done         : one-cycle pulse in FINISH
//   ch_strobe    : one-cycle pulse on the first cycle of each channel
module demux_scan_seq #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             stop,
  input  logic             din,
  input  logic [DIV_W-1:0] dwell,
  output logic             d,
  output logic [1:0]       s,
  output logic             busy,
  output logic             done,
  output logic             ch_strobe
);

  typedef enum logic [1:0] {IDLE, DWELL, FINISH} state_t;

  state_t           r_state, w_next;
  logic             r_din, r_mode, r_pend, r_strb;
  logic [DIV_W-1:0] r_dwell, r_cnt;
  logic [1:0]       r_s;
  logic             w_end, w_stop, w_last;

  // Compare before increment, so dwell = 2^DIV_W-1 never overflows the counter.
  assign w_end  = (r_cnt == r_dwell);
  // A stop arriving on the final cycle of a channel still ends that channel.
  assign w_stop = r_mode & (r_pend | stop);
  assign w_last = w_end & (w_stop | (~r_mode & (r_s == 2'b11)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = DWELL;
      DWELL:   if (w_last) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latched inputs, dwell counter, channel select, strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din   <= 1'b0;
      r_mode  <= 1'b0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_s     <= 2'b00;
      r_pend  <= 1'b0;
      r_strb  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Clearing here lets start win over a simultaneous stop.
          r_pend <= 1'b0;
          r_strb <= 1'b0;
          if (start) begin
            r_din   <= din;
            r_mode  <= mode;
            r_dwell <= dwell;
            r_cnt   <= '0;
            r_s     <= 2'b00;
            r_strb  <= 1'b1;
          end
        end
        DWELL: begin
          if (stop) r_pend <= 1'b1;
          r_strb <= 1'b0;
          if (!w_end) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_last) begin
            // In continuous mode, 11 wraps naturally to 00.
            r_s    <= r_s + 2'b01;
            r_cnt  <= '0;
            r_strb <= 1'b1;
          end
        end
        default: r_strb <= 1'b0;
      endcase
    end
  end

  // Output decode of registered state; no combinational input paths.
  always_comb begin
    busy      = (r_state == DWELL);
    done      = (r_state == FINISH);
    d         = busy & r_din;
    s         = r_s;
    ch_strobe = r_strb;
  end

endmodule

// File: doc/demux_scan_seq.md
Name: demux_scan_seq

Overview:
- Sequencer directly upstream of the 1-to-4 data-flow demultiplexer; produces its `d` data bit and `s[1:0]` select.
- On `start`, latches a data bit and a dwell length, then steps `s` through channels 0..3, holding each for a programmable number of clocks.
- Runs one sweep (one-shot) or repeats sweeps (continuous) until stopped.
- Outside a sweep, `d` is held at 0, so all four demux outputs are low.

Parameters:
- DIV_W, 8, width of the dwell-count input and internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- mode  input  1  0 = one-shot sweep, 1 = continuous; latched with start.
- stop  input  1  continuous mode: end operation at the end of the current channel dwell.
- din  input  1  data bit to route; latched with start.
- dwell  input  DIV_W  cycles per channel minus 1; latched with start.
- d  output  1  data bit to demux.
- s  output  2  channel select to demux.
- busy  output  1  high while a sweep is active (DWELL state).
- done  output  1  one-cycle pulse when operation ends.
- ch_strobe  output  1  one-cycle pulse on the first cycle of each channel dwell.

Behaviour:
- States: IDLE, DWELL, FINISH.
- Reset (rst_n low, async): state = IDLE, s = 2'b00, d = 0, busy = 0, done = 0, ch_strobe = 0, counter = 0, latched regs = 0. Outputs are registered and take reset values immediately on rst_n falling.
- IDLE, start = 1 at a rising edge:
  - Latch din, mode and dwell; counter = 0; s = 00; d = latched din.
  - busy = 1, ch_strobe = 1 from the next cycle; go to DWELL.
  - Latency start -> `d`/`s` valid: 1 clock.
- IDLE, start = 0: outputs hold (s = last value, d = 0, busy = 0).
- DWELL:
  - Counter increments each cycle while counter != latched dwell.
  - When counter == latched dwell:
    - Not last channel (s != 11): s <= s + 1, counter <= 0, ch_strobe pulses.
    - s == 11, one-shot: go to FINISH.
    - s == 11, continuous, stop not seen: wrap s <= 00, counter <= 0, ch_strobe pulses.
  - Each channel is held exactly dwell+1 cycles. dwell = 0 means one cycle per channel; a full sweep is 4 cycles.
  - Counter is DIV_W bits; maximum dwell = 2^DIV_W - 1, with no counter overflow since comparison happens before increment.
- stop handling:
  - A pending-stop flag sets on stop = 1 in DWELL and clears in IDLE.
  - At the end of the current channel dwell, go to FINISH regardless of s.
  - Ignored in one-shot mode and in IDLE.
- FINISH (1 cycle): d = 0, busy = 0, done = 1 for that cycle, s holds last channel; then go to IDLE.
- start asserted while busy or in FINISH: ignored, with no re-latch.
- start and stop asserted together in IDLE: start wins; stop is ignored because the pending flag is cleared in IDLE.
- din/dwell/mode changes mid-sweep have no effect; latched copies are used.
- Reset mid-sweep returns to IDLE immediately. No done pulse is generated.
- Combined with the demux, exactly one output y[s] equals the latched din during DWELL; all outputs are 0 otherwise.

Test Plan:
- Reset check: rst_n = 0 mid-sweep (s = 10) -> s = 00, d = 0, busy = 0, done = 0 asynchronously, before the next clk edge.
- One-shot, din = 1, dwell = 0: s = 00, 01, 10, 11 on 4 consecutive cycles after start; ch_strobe high all 4 cycles; done pulses on cycle 5; demux y = 0001, 0010, 0100, 1000 then 0000.
- One-shot, din = 1, dwell = 2: each s value held 3 cycles; busy high 12 cycles; done exactly 1 cycle; start pulsed again during busy -> no restart, sweep length still 12.
- Continuous, dwell = 1: s wraps 11 -> 00 with no gap and no done; stop asserted at s = 01 mid-dwell -> channel 01 completes its 2 cycles, then FINISH with done = 1; s stays 01.
- Data latch: din = 0 latched, then din toggled to 1 mid-sweep -> d stays 0 for the whole sweep; y = 0000 throughout.
- Max dwell: DIV_W = 3, dwell = 7 -> 8 cycles per channel, 32 cycles busy, no early wrap.
